// File: rtl/fw_pkg.sv
// Shared types for the firewall verdict engine: FSM states, rule record, actions.
package fw_pkg;

    localparam int FW_KEY_WIDTH = 32;

    localparam logic FW_ACTION_DENY   = 1'b0;
    localparam logic FW_ACTION_PERMIT = 1'b1;

    typedef enum logic [1:0] {
        FW_IDLE,
        FW_SCAN,
        FW_RESPOND
    } fw_state_t;

    typedef struct packed {
        logic                    enable;
        logic                    action;
        logic [FW_KEY_WIDTH-1:0] value;
        logic [FW_KEY_WIDTH-1:0] mask;
    } fw_rule_t;

    // Mask bits set to 1 are compared; an enabled rule with an all-zero mask matches anything.
    function automatic logic fw_rule_match(fw_rule_t rule, logic [FW_KEY_WIDTH-1:0] key);
        return rule.enable && (((key ^ rule.value) & rule.mask) == '0);
    endfunction

endpackage

// File: rtl/fw_rule_table.sv
// Rule register array with write port and indexed read mux.
// Optional per-rule saturating hit counters under FW_RULE_HIT_COUNT_EN.
module fw_rule_table
    import fw_pkg::*;
#(
    parameter int NUM_RULES = 16,
    parameter int IDX_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [IDX_WIDTH-1:0] wr_idx,
    input  fw_rule_t             wr_rule,
    input  logic [IDX_WIDTH-1:0] rd_idx,
`ifdef FW_RULE_HIT_COUNT_EN
    input  logic                 cnt_inc,
    input  logic [IDX_WIDTH-1:0] cnt_inc_idx,
    input  logic [IDX_WIDTH-1:0] cnt_rd_idx,
    output logic [15:0]          cnt_rd_data,
`endif
    output fw_rule_t             rd_rule
);

    fw_rule_t rules_q [NUM_RULES];
    fw_rule_t rules_d [NUM_RULES];

    always_comb begin
        rules_d = rules_q;
        for (int i = 0; i < NUM_RULES; i++) begin
            if (wr_en && (wr_idx == IDX_WIDTH'(i))) rules_d[i] = wr_rule;
        end
    end

    // Reads see the registered contents, so a same-cycle write is not yet visible.
    always_comb begin
        rd_rule = '0;
        for (int i = 0; i < NUM_RULES; i++) begin
            if (rd_idx == IDX_WIDTH'(i)) rd_rule = rules_q[i];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_RULES; i++) begin
            if (rst) rules_q[i] <= '0;
            else     rules_q[i] <= rules_d[i];
        end
    end

`ifdef FW_RULE_HIT_COUNT_EN
    logic [15:0] cnt_q [NUM_RULES];
    logic [15:0] cnt_d [NUM_RULES];

    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < NUM_RULES; i++) begin
            if (cnt_inc && (cnt_inc_idx == IDX_WIDTH'(i)) && (cnt_q[i] != 16'hFFFF))
                cnt_d[i] = cnt_q[i] + 16'd1;
            // Rewriting a rule restarts its statistics, even against a same-cycle hit.
            if (wr_en && (wr_idx == IDX_WIDTH'(i))) cnt_d[i] = '0;
        end
    end

    always_comb begin
        cnt_rd_data = '0;
        for (int i = 0; i < NUM_RULES; i++) begin
            if (cnt_rd_idx == IDX_WIDTH'(i)) cnt_rd_data = cnt_q[i];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_RULES; i++) begin
            if (rst) cnt_q[i] <= '0;
            else     cnt_q[i] <= cnt_d[i];
        end
    end
`endif

endmodule

// File: rtl/fw_verdict_engine.sv
// Firewall verdict engine: pops {key, tag}, scans rules lowest index first, returns safe/unsafe.
// Optional hit counters when FW_RULE_HIT_COUNT_EN is defined.
//
// state      | meaning
// FW_IDLE    | ready to pop a request
// FW_SCAN    | compare rule[idx_q] against latched key, one rule per cycle
// FW_RESPOND | verdict presented, held until rsp_ready
module fw_verdict_engine
    import fw_pkg::*;
#(
    parameter  int KEY_WIDTH = 32,
    parameter  int TAG_WIDTH = 11,
    parameter  int NUM_RULES = 16,
    localparam int IDX_WIDTH = $clog2(NUM_RULES)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [KEY_WIDTH-1:0] req_key,
    input  logic [TAG_WIDTH-1:0] req_tag,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [TAG_WIDTH-1:0] rsp_tag,
    output logic                 rsp_safe,
    output logic                 rsp_rule_hit,
    output logic [IDX_WIDTH-1:0] rsp_rule_idx,
    input  logic                 rule_wr_en,
    input  logic [IDX_WIDTH-1:0] rule_wr_idx,
    input  logic                 rule_wr_enable,
    input  logic                 rule_wr_action,
    input  logic [KEY_WIDTH-1:0] rule_wr_value,
    input  logic [KEY_WIDTH-1:0] rule_wr_mask,
    input  logic                 default_action,
`ifdef FW_RULE_HIT_COUNT_EN
    input  logic [IDX_WIDTH-1:0] hit_cnt_rd_idx,
    output logic [15:0]          hit_cnt_rd_data,
`endif
    output logic                 busy
);

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_RULES - 1);

    fw_state_t            state_q, state_d;
    logic [KEY_WIDTH-1:0] key_q, key_d;
    logic [TAG_WIDTH-1:0] tag_q, tag_d;
    logic [IDX_WIDTH-1:0] idx_q, idx_d;
    logic                 safe_q, safe_d;
    logic                 hit_q, hit_d;
    logic [IDX_WIDTH-1:0] ridx_q, ridx_d;

    fw_rule_t wr_rule;
    fw_rule_t rd_rule;
    logic     rule_match;

    always_comb begin
        wr_rule        = '0;
        wr_rule.enable = rule_wr_enable;
        wr_rule.action = rule_wr_action;
        wr_rule.value  = FW_KEY_WIDTH'(rule_wr_value);
        wr_rule.mask   = FW_KEY_WIDTH'(rule_wr_mask);
    end

    fw_rule_table #(
        .NUM_RULES (NUM_RULES),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_rule_table (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (rule_wr_en),
        .wr_idx      (rule_wr_idx),
        .wr_rule     (wr_rule),
        .rd_idx      (idx_q),
`ifdef FW_RULE_HIT_COUNT_EN
        .cnt_inc     (rsp_valid && rsp_ready && hit_q),
        .cnt_inc_idx (ridx_q),
        .cnt_rd_idx  (hit_cnt_rd_idx),
        .cnt_rd_data (hit_cnt_rd_data),
`endif
        .rd_rule     (rd_rule)
    );

    assign rule_match = fw_rule_match(rd_rule, FW_KEY_WIDTH'(key_q));

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        tag_d   = tag_q;
        idx_d   = idx_q;
        safe_d  = safe_q;
        hit_d   = hit_q;
        ridx_d  = ridx_q;
        case (state_q)
            FW_IDLE: begin
                if (req_valid) begin
                    key_d   = req_key;
                    tag_d   = req_tag;
                    idx_d   = '0;
                    state_d = FW_SCAN;
                end
            end
            FW_SCAN: begin
                if (rule_match) begin
                    safe_d  = rd_rule.action;
                    hit_d   = 1'b1;
                    ridx_d  = idx_q;
                    state_d = FW_RESPOND;
                end else if (idx_q == LAST_IDX) begin
                    safe_d  = default_action;
                    hit_d   = 1'b0;
                    ridx_d  = '0;
                    state_d = FW_RESPOND;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            FW_RESPOND: begin
                if (rsp_ready) state_d = FW_IDLE;
            end
            default: state_d = FW_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FW_IDLE;
            key_q   <= '0;
            tag_q   <= '0;
            idx_q   <= '0;
            safe_q  <= 1'b0;
            hit_q   <= 1'b0;
            ridx_q  <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            tag_q   <= tag_d;
            idx_q   <= idx_d;
            safe_q  <= safe_d;
            hit_q   <= hit_d;
            ridx_q  <= ridx_d;
        end
    end

    assign req_ready    = (state_q == FW_IDLE);
    assign rsp_valid    = (state_q == FW_RESPOND);
    assign busy         = (state_q != FW_IDLE);
    assign rsp_tag      = tag_q;
    assign rsp_safe     = safe_q;
    assign rsp_rule_hit = hit_q;
    assign rsp_rule_idx = ridx_q;

endmodule

// File: tb/tb_fw_verdict_engine.sv
// Scoreboard bench for fw_verdict_engine; hit counters checked when FW_RULE_HIT_COUNT_EN is defined.
module tb_fw_verdict_engine;

    localparam int KW = 32;
    localparam int TW = 11;
    localparam int NR = 16;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [KW-1:0] req_key;
    logic [TW-1:0] req_tag;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [TW-1:0] rsp_tag;
    logic          rsp_safe;
    logic          rsp_rule_hit;
    logic [IW-1:0] rsp_rule_idx;
    logic          rule_wr_en;
    logic [IW-1:0] rule_wr_idx;
    logic          rule_wr_enable;
    logic          rule_wr_action;
    logic [KW-1:0] rule_wr_value;
    logic [KW-1:0] rule_wr_mask;
    logic          default_action;
    logic          busy;
`ifdef FW_RULE_HIT_COUNT_EN
    logic [IW-1:0] hit_cnt_rd_idx = '0;
    logic [15:0]   hit_cnt_rd_data;
    logic [15:0]   cnt_mdl [NR];
`endif

    always #5 clk = ~clk;

    fw_verdict_engine dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_key        (req_key),
        .req_tag        (req_tag),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_tag        (rsp_tag),
        .rsp_safe       (rsp_safe),
        .rsp_rule_hit   (rsp_rule_hit),
        .rsp_rule_idx   (rsp_rule_idx),
        .rule_wr_en     (rule_wr_en),
        .rule_wr_idx    (rule_wr_idx),
        .rule_wr_enable (rule_wr_enable),
        .rule_wr_action (rule_wr_action),
        .rule_wr_value  (rule_wr_value),
        .rule_wr_mask   (rule_wr_mask),
        .default_action (default_action),
`ifdef FW_RULE_HIT_COUNT_EN
        .hit_cnt_rd_idx (hit_cnt_rd_idx),
        .hit_cnt_rd_data(hit_cnt_rd_data),
`endif
        .busy           (busy)
    );

    typedef struct packed {
        logic          en;
        logic          act;
        logic [KW-1:0] val;
        logic [KW-1:0] mask;
    } rule_t;

    typedef struct packed {
        logic [TW-1:0] tag;
        logic          safe;
        logic          hit;
        logic [IW-1:0] idx;
        logic [7:0]    lat;
    } exp_t;

    rule_t mdl [NR];
    exp_t  exp_q [$];
    int    n_cmp = 0;
    int    n_err = 0;
    bit    hold_rdy = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: first enabled rule whose cared-for bits equal the key. Rule k is looked at
    // k+1 cycles after acceptance; a write issued in cycle wc is visible to rules k >= wc.
    function automatic exp_t predict(input logic [KW-1:0] key, input logic [TW-1:0] tag,
                                     input int wc, input int widx, input rule_t wr);
        exp_t  e;
        rule_t r;
        e.tag = tag;
        for (int k = 0; k < NR; k++) begin
            r = mdl[k];
            if (wc > 0 && k == widx && wc <= k) r = wr;
            if (r.en && ((key ^ r.val) & r.mask) == '0) begin
                e.safe = r.act;
                e.hit  = 1'b1;
                e.idx  = IW'(k);
                e.lat  = 8'(k + 2);
                return e;
            end
        end
        e.safe = default_action;
        e.hit  = 1'b0;
        e.idx  = '0;
        e.lat  = 8'(NR + 1);
        return e;
    endfunction

    function automatic rule_t rand_rule();
        rule_t r;
        r.en  = ($urandom_range(0, 3) != 0);
        r.act = 1'($urandom_range(0, 1));
        r.val = $urandom;
        case ($urandom_range(0, 15))
            0:       r.mask = '0;
            1, 2, 3: r.mask = '1;
            4, 5, 6: r.mask = 32'hFF00_0000;
            7, 8:    r.mask = $urandom;
            default: r.mask = $urandom & $urandom & $urandom;
        endcase
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_rule(input int idx, input rule_t r);
        rule_wr_en     = 1'b1;
        rule_wr_idx    = IW'(idx);
        rule_wr_enable = r.en;
        rule_wr_action = r.act;
        rule_wr_value  = r.val;
        rule_wr_mask   = r.mask;
        tick();
        rule_wr_en = 1'b0;
        mdl[idx]   = r;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 300) begin
            tick();
            n++;
        end
        check("wait_idle_busy", 64'(busy), 64'(0));
    endtask

    // Presents a request until popped; optionally writes a rule wc cycles after acceptance.
    task automatic issue(input logic [KW-1:0] key, input logic [TW-1:0] tag, input bit push,
                         input int wc, input int widx, input rule_t wr);
        int n = 0;
        if (push) exp_q.push_back(predict(key, tag, wc, widx, wr));
        req_valid = 1'b1;
        req_key   = key;
        req_tag   = tag;
        forever begin
            @(negedge clk);
            if (req_ready || n > 300) break;
            n++;
        end
        check("accept_wait", 64'(req_ready), 64'(1));
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_key   = $urandom;
        req_tag   = TW'($urandom);
        if (wc > 0) begin
            repeat (wc - 1) tick();
            write_rule(widx, wr);
        end
    endtask

    always begin
        @(posedge clk);
        #2;
        rsp_ready = hold_rdy ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    // Monitor: pops the scoreboard on each new verdict, measures latency from the accept cycle.
    int                ncnt = 0;
    int                start_cnt = 0;
    bit                prev = 1'b0;
    exp_t              cur;
    logic [TW+IW+1:0]  held;

    always @(negedge clk) begin
        if (rst) begin
            prev = 1'b0;
`ifdef FW_RULE_HIT_COUNT_EN
            for (int i = 0; i < NR; i++) cnt_mdl[i] = '0;
`endif
        end else begin
            if (rsp_valid) begin
                if (!prev) begin
                    if (exp_q.size() == 0) begin
                        check("rsp_unexpected", 64'(rsp_valid), 64'(0));
                        cur = '0;
                    end else begin
                        cur = exp_q.pop_front();
                        check("rsp_tag", 64'(rsp_tag), 64'(cur.tag));
                        check("rsp_safe", 64'(rsp_safe), 64'(cur.safe));
                        check("rsp_rule_hit", 64'(rsp_rule_hit), 64'(cur.hit));
                        check("rsp_rule_idx", 64'(rsp_rule_idx), 64'(cur.idx));
                        check("rsp_latency", 64'(ncnt - start_cnt), 64'(cur.lat));
                    end
                    held = {rsp_tag, rsp_safe, rsp_rule_hit, rsp_rule_idx};
                end else begin
                    check("rsp_stable", 64'({rsp_tag, rsp_safe, rsp_rule_hit, rsp_rule_idx}), 64'(held));
                end
                check("req_ready_during_rsp", 64'(req_ready), 64'(0));
`ifdef FW_RULE_HIT_COUNT_EN
                if (rsp_ready && cur.hit && cnt_mdl[cur.idx] != 16'hFFFF)
                    cnt_mdl[cur.idx] = cnt_mdl[cur.idx] + 16'd1;
`endif
                prev = !rsp_ready;
            end else begin
                prev = 1'b0;
            end
            if (req_valid && req_ready) start_cnt = ncnt;
`ifdef FW_RULE_HIT_COUNT_EN
            if (rule_wr_en) cnt_mdl[rule_wr_idx] = '0;
`endif
        end
        ncnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rule_t none;
        none           = '0;
        rst            = 1'b1;
        req_valid      = 1'b0;
        req_key        = '0;
        req_tag        = '0;
        rule_wr_en     = 1'b0;
        rule_wr_idx    = '0;
        rule_wr_enable = 1'b0;
        rule_wr_action = 1'b0;
        rule_wr_value  = '0;
        rule_wr_mask   = '0;
        default_action = 1'b0;
        for (int i = 0; i < NR; i++) mdl[i] = '0;
        repeat (3) tick();
        rst = 1'b0;

        check("reset_rsp_valid", 64'(rsp_valid), 64'(0));
        check("reset_req_ready", 64'(req_ready), 64'(1));
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_rsp_tag", 64'(rsp_tag), 64'(0));
        check("reset_rsp_safe", 64'(rsp_safe), 64'(0));
        check("reset_rsp_hit", 64'(rsp_rule_hit), 64'(0));
        check("reset_rsp_idx", 64'(rsp_rule_idx), 64'(0));

        // Empty table: default verdict after a full scan.
        default_action = 1'b1;
        issue(32'h0A00_0001, 11'd5, 1'b1, 0, 0, none);
        wait_idle();

        // Priority between a narrow deny and a catch-all permit.
        write_rule(3, '{en: 1'b1, act: 1'b0, val: 32'h0A00_0000, mask: 32'hFF00_0000});
        write_rule(7, '{en: 1'b1, act: 1'b1, val: 32'h0, mask: 32'h0});
        default_action = 1'b0;
        repeat (3) issue(32'h0A12_3456, 11'h7FF, 1'b1, 0, 0, none);
        issue(32'h0B00_0000, 11'd1, 1'b1, 0, 0, none);
        wait_idle();
`ifdef FW_RULE_HIT_COUNT_EN
        hit_cnt_rd_idx = 4'd3;
        #1;
        check("hit_cnt_rule3", 64'(hit_cnt_rd_data), 64'(cnt_mdl[3]));
        write_rule(3, '{en: 1'b1, act: 1'b0, val: 32'h0A00_0000, mask: 32'hFF00_0000});
        #1;
        check("hit_cnt_rule3_cleared", 64'(hit_cnt_rd_data), 64'(cnt_mdl[3]));
`endif

        // Consumer stalls while the next request is already waiting.
        hold_rdy = 1'b1;
        tick();
        issue(32'h0A00_0001, 11'h011, 1'b1, 0, 0, none);
        fork
            issue(32'h0B00_0000, 11'h022, 1'b1, 0, 0, none);
            begin
                repeat (25) tick();
                hold_rdy = 1'b0;
            end
        join
        wait_idle();

        // Reset in cycle 4 of a scan drops the request and clears the table.
        issue(32'h0B00_0000, 11'h033, 1'b0, 0, 0, none);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midscan_rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("midscan_rst_req_ready", 64'(req_ready), 64'(1));
        check("midscan_rst_busy", 64'(busy), 64'(0));
        for (int i = 0; i < NR; i++) mdl[i] = '0;
        default_action = 1'b0;
        issue(32'h0A12_3456, 11'h034, 1'b1, 0, 0, none);
        wait_idle();

        // Rule 10 written while rule 2 is being compared is still seen by the scan.
        issue(32'h1234_5678, 11'h044, 1'b1, 3, 10,
              '{en: 1'b1, act: 1'b0, val: 32'h1234_5678, mask: 32'hFFFF_FFFF});
        wait_idle();

        // First and last slots.
        write_rule(0, '{en: 1'b1, act: 1'b1, val: 32'hDEAD_0000, mask: 32'hFFFF_0000});
        write_rule(15, '{en: 1'b1, act: 1'b1, val: 32'hCAFE_0000, mask: 32'hFFFF_0000});
        issue(32'hDEAD_1234, 11'h055, 1'b1, 0, 0, none);
        issue(32'hCAFE_BEEF, 11'h066, 1'b1, 0, 0, none);
        wait_idle();

        for (int it = 0; it < 60; it++) begin
            int    j;
            int    wc;
            logic [KW-1:0] key;
            wait_idle();
            repeat ($urandom_range(0, 2)) write_rule($urandom_range(0, NR - 1), rand_rule());
            default_action = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) begin
                j   = $urandom_range(0, NR - 1);
                key = mdl[j].val ^ ($urandom & ~mdl[j].mask);
            end else begin
                key = $urandom;
            end
            wc = ($urandom_range(0, 3) == 0) ? $urandom_range(1, NR) : 0;
            issue(key, TW'($urandom), 1'b1, wc, $urandom_range(0, NR - 1), rand_rule());
        end
        wait_idle();

        begin
            int n = 0;
            while (exp_q.size() != 0 && n < 100) begin
                tick();
                n++;
            end
        end
        check("scoreboard_drained", 64'(exp_q.size()), 64'(0));

`ifdef FW_RULE_HIT_COUNT_EN
        for (int i = 0; i < NR; i++) begin
            hit_cnt_rd_idx = IW'(i);
            #1;
            check("hit_cnt_final", 64'(hit_cnt_rd_data), 64'(cnt_mdl[i]));
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
